// File: rtl/elevator_defs.sv
// Shared definitions for the elevator car controller: FSM state encoding,
// travel direction constants and default geometry/timing values.
package elevator_defs;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    localparam int DEF_NUM_FLOORS   = 8;
    localparam int DEF_TRAVEL_TICKS = 8;
    localparam int DEF_DOOR_TICKS   = 12;

endpackage

// File: rtl/req_scan.sv
// Combinational scan of the latched call vector relative to the car position:
// reports calls strictly above, strictly below and at the current floor.
module req_scan
    import elevator_defs::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FW         = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FW-1:0]         floor,
    output logic                  any_above,
    output logic                  any_below,
    output logic                  at_floor
);

    // Classify every pending call by its position relative to the car.
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        at_floor  = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (FW'(i) > floor) begin
                any_above = any_above | pending[i];
            end else if (FW'(i) < floor) begin
                any_below = any_below | pending[i];
            end else begin
                at_floor = pending[i];
            end
        end
    end

endmodule

// File: rtl/elevator_ctrl.sv
// Elevator car-motion controller. Latches call pulses, serves them in SCAN
// order and paces travel and door dwell with an external up-counting timer
// whose count is restarted by a one-cycle tmr_rst pulse on every phase entry.
module elevator_ctrl
    import elevator_defs::*;
#(
    parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
    parameter int FW           = $clog2(NUM_FLOORS),
    parameter int TRAVEL_TICKS = DEF_TRAVEL_TICKS,
    parameter int DOOR_TICKS   = DEF_DOOR_TICKS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic [3:0]            tmr_period,
    output logic                  tmr_rst,
    output logic                  tmr_dir,
    output logic [FW-1:0]         floor,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    // A phase is over on the cycle the timer shows its last count.
    localparam logic [3:0] TRAVEL_LAST = 4'(TRAVEL_TICKS - 1);
    localparam logic [3:0] DOOR_LAST   = 4'(DOOR_TICKS - 1);

    state_t                  state;
    state_t                  state_d;
    logic [FW-1:0]           floor_d;
    logic [FW-1:0]           floor_up;
    logic [FW-1:0]           floor_dn;
    logic [NUM_FLOORS-1:0]   pending_d;
    logic [NUM_FLOORS-1:0]   clr;
    logic                    last_dir;
    logic                    last_dir_d;
    logic                    restart;
    logic                    phase_end;
    logic                    any_above;
    logic                    any_below;
    logic                    at_floor;

    req_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FW         (FW)
    ) u_scan (
        .pending    (pending),
        .floor      (floor),
        .any_above  (any_above),
        .any_below  (any_below),
        .at_floor   (at_floor)
    );

    // The timer is only ever used counting up.
    assign tmr_dir  = 1'b1;
    assign floor_up = floor + FW'(1);
    assign floor_dn = floor - FW'(1);

    // Next-state, floor, direction memory and call-latch update.
    always_comb begin
        state_d    = state;
        floor_d    = floor;
        last_dir_d = last_dir;
        restart    = 1'b0;
        clr        = '0;
        // The restart pulse itself masks the stale count of the previous phase.
        phase_end  = !tmr_rst &&
                     (tmr_period == ((state == DOOR_OPEN) ? DOOR_LAST : TRAVEL_LAST));

        case (state)
            IDLE: begin
                if (at_floor) begin
                    state_d      = DOOR_OPEN;
                    clr[floor]   = 1'b1;
                    restart      = 1'b1;
                end else if (any_above) begin
                    state_d    = MOVE_UP;
                    last_dir_d = UP;
                    restart    = 1'b1;
                end else if (any_below) begin
                    state_d    = MOVE_DOWN;
                    last_dir_d = DOWN;
                    restart    = 1'b1;
                end
            end

            MOVE_UP: begin
                if (phase_end) begin
                    floor_d = floor_up;
                    restart = 1'b1;
                    if (pending[floor_up]) begin
                        state_d       = DOOR_OPEN;
                        clr[floor_up] = 1'b1;
                    end
                end
            end

            MOVE_DOWN: begin
                if (phase_end) begin
                    floor_d = floor_dn;
                    restart = 1'b1;
                    if (pending[floor_dn]) begin
                        state_d       = DOOR_OPEN;
                        clr[floor_dn] = 1'b1;
                    end
                end
            end

            DOOR_OPEN: begin
                // A call for this floor while the door is open only extends the dwell.
                clr[floor] = 1'b1;
                if (req[floor]) begin
                    restart = 1'b1;
                end else if (phase_end) begin
                    if (last_dir == UP && any_above) begin
                        state_d = MOVE_UP;
                        restart = 1'b1;
                    end else if (last_dir == DOWN && any_below) begin
                        state_d = MOVE_DOWN;
                        restart = 1'b1;
                    end else if (any_above) begin
                        state_d    = MOVE_UP;
                        last_dir_d = UP;
                        restart    = 1'b1;
                    end else if (any_below) begin
                        state_d    = MOVE_DOWN;
                        last_dir_d = DOWN;
                        restart    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase

        // Clearing the served floor takes precedence over a new call for it.
        pending_d = (pending | req) & ~clr;
    end

    // State, position, call latch and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            floor       <= '0;
            pending     <= '0;
            last_dir    <= UP;
            moving_up   <= 1'b0;
            moving_down <= 1'b0;
            door_open   <= 1'b0;
            tmr_rst     <= 1'b1;
        end else begin
            state       <= state_d;
            floor       <= floor_d;
            pending     <= pending_d;
            last_dir    <= last_dir_d;
            moving_up   <= (state_d == MOVE_UP);
            moving_down <= (state_d == MOVE_DOWN);
            door_open   <= (state_d == DOOR_OPEN);
            tmr_rst     <= restart;
        end
    end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl with an attached up/down timer model, a vector
// table, directed multi-cycle scenarios and a randomized run against a
// cycle-count based reference model of the car behaviour.
module tb_elevator_ctrl;

    localparam int NF = 8;
    localparam int FW = 3;
    localparam int TT = 8;
    localparam int DT = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [NF-1:0] req;
    logic [3:0]    tmr_period = 4'd0;
    logic          tmr_rst;
    logic          tmr_dir;
    logic [FW-1:0] floor;
    logic          moving_up;
    logic          moving_down;
    logic          door_open;
    logic [NF-1:0] pending;

    int total = 0;
    int bad   = 0;

    elevator_ctrl #(
        .NUM_FLOORS   (NF),
        .FW           (FW),
        .TRAVEL_TICKS (TT),
        .DOOR_TICKS   (DT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .tmr_period  (tmr_period),
        .tmr_rst     (tmr_rst),
        .tmr_dir     (tmr_dir),
        .floor       (floor),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .door_open   (door_open),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    // Timer sitting next to the controller.
    always @(posedge clk) begin
        if (tmr_rst) tmr_period <= 4'd0;
        else if (tmr_dir) tmr_period <= tmr_period + 4'd1;
        else tmr_period <= tmr_period - 4'd1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          rst;
        logic [7:0]  req;
        int          reps;
        int          floor;
        bit          up;
        bit          dn;
        bit          door;
        bit          trst;
        logic [7:0]  pend;
    } vec_t;

    function automatic vec_t mk(bit r, logic [7:0] q, int n, int f, bit u, bit d,
                                bit o, bit t, logic [7:0] p);
        vec_t v;
        v.rst = r; v.req = q; v.reps = n; v.floor = f; v.up = u; v.dn = d;
        v.door = o; v.trst = t; v.pend = p;
        return v;
    endfunction

    function automatic int pack(int f, bit u, bit d, bit o, bit t, logic [7:0] p);
        return (f << 12) | (int'(u) << 11) | (int'(d) << 10) | (int'(o) << 9) |
               (int'(t) << 8) | int'(p);
    endfunction

    function automatic int dut_vec();
        return pack(int'(floor), moving_up, moving_down, door_open, tmr_rst, pending);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Reference model: car position, call set, activity and remaining cycles
    // of the current phase (a phase of LIMIT ticks occupies LIMIT+1 cycles).
    int         m_floor;
    logic [7:0] m_pend;
    int         m_mode;     // 0 idle, 1 going up, 2 going down, 3 door open
    int         m_left;
    bit         m_lastup;
    bit         m_trst;

    task automatic m_enter(input int mode);
        m_mode = mode;
        m_trst = 1'b1;
        m_left = (mode == 3) ? DT : TT;
    endtask

    task automatic model_step(input bit r_rst, input logic [7:0] r);
        logic [7:0] np;
        bit ab;
        bit be;
        if (r_rst) begin
            m_floor = 0; m_pend = '0; m_mode = 0; m_left = 0;
            m_lastup = 1'b1; m_trst = 1'b1;
            return;
        end
        ab = 1'b0;
        be = 1'b0;
        for (int i = 0; i < NF; i++) begin
            if (m_pend[i] && i > m_floor) ab = 1'b1;
            if (m_pend[i] && i < m_floor) be = 1'b1;
        end
        np = m_pend | r;
        m_trst = 1'b0;
        case (m_mode)
            0: begin
                if (m_pend[m_floor]) begin
                    np[m_floor] = 1'b0;
                    m_enter(3);
                end else if (ab) begin
                    m_lastup = 1'b1; m_enter(1);
                end else if (be) begin
                    m_lastup = 1'b0; m_enter(2);
                end
            end
            1, 2: begin
                if (m_left == 0) begin
                    m_floor = m_floor + ((m_mode == 1) ? 1 : -1);
                    if (m_pend[m_floor]) begin
                        np[m_floor] = 1'b0;
                        m_enter(3);
                    end else begin
                        m_enter(m_mode);
                    end
                end else begin
                    m_left--;
                end
            end
            default: begin
                np[m_floor] = 1'b0;
                if (r[m_floor]) begin
                    m_enter(3);
                end else if (m_left == 0) begin
                    if (m_lastup && ab) m_enter(1);
                    else if (!m_lastup && be) m_enter(2);
                    else if (ab) begin m_lastup = 1'b1; m_enter(1); end
                    else if (be) begin m_lastup = 1'b0; m_enter(2); end
                    else m_mode = 0;
                end else begin
                    m_left--;
                end
            end
        endcase
        m_pend = np;
    endtask

    initial begin
        vec_t tab[$];
        int   cnt;
        int   n;
        int   got[3];
        bit   found;
        bit   prev;
        bit   rv;
        logic [7:0] rq;

        rst = 1'b1;
        req = '0;

        // Reset, call at the current floor, full dwell, one-floor trip.
        tab.push_back(mk(1, 8'hFF, 2,  0, 0, 0, 0, 1, 8'h00));
        tab.push_back(mk(0, 8'h00, 1,  0, 0, 0, 0, 0, 8'h00));
        tab.push_back(mk(0, 8'h01, 1,  0, 0, 0, 0, 0, 8'h01));
        tab.push_back(mk(0, 8'h00, 1,  0, 0, 0, 1, 1, 8'h00));
        tab.push_back(mk(0, 8'h00, 12, 0, 0, 0, 1, 0, 8'h00));
        tab.push_back(mk(0, 8'h00, 1,  0, 0, 0, 0, 0, 8'h00));
        tab.push_back(mk(0, 8'h02, 1,  0, 0, 0, 0, 0, 8'h02));
        tab.push_back(mk(0, 8'h00, 1,  0, 1, 0, 0, 1, 8'h02));
        tab.push_back(mk(0, 8'h00, 8,  0, 1, 0, 0, 0, 8'h02));
        tab.push_back(mk(0, 8'h00, 1,  1, 0, 0, 1, 1, 8'h00));
        tab.push_back(mk(0, 8'h00, 12, 1, 0, 0, 1, 0, 8'h00));
        tab.push_back(mk(0, 8'h00, 1,  1, 0, 0, 0, 0, 8'h00));

        for (int i = 0; i < tab.size(); i++) begin
            for (int k = 0; k < tab[i].reps; k++) begin
                rst = tab[i].rst;
                req = tab[i].req;
                step();
                chk($sformatf("tab%0d.%0d", i, k), dut_vec(),
                    pack(tab[i].floor, tab[i].up, tab[i].dn, tab[i].door,
                         tab[i].trst, tab[i].pend));
            end
        end
        chk("tmr_dir", int'(tmr_dir), 1);

        // Single trip 0 -> 3.
        do_reset();
        req = 8'h08;
        step();
        req = 8'h00;
        chk("trip latch", int'(pending), 8'h08);
        step();
        chk("trip start up", int'(moving_up), 1);
        chk("trip start trst", int'(tmr_rst), 1);
        for (int k = 1; k <= 27; k++) begin
            step();
            if (k % 9 == 0) chk($sformatf("trip floor@%0d", k), int'(floor), k / 9);
            if (k == 9) chk("trip moving", int'(moving_up), 1);
        end
        chk("trip door", int'(door_open), 1);
        chk("trip pend3 clr", int'(pending[3]), 0);
        chk("trip up off", int'(moving_up), 0);
        cnt = 1;
        for (int g = 0; g < 40 && door_open; g++) begin
            step();
            if (door_open) cnt++;
        end
        chk("trip dwell", cnt, DT + 1);
        chk("trip idle", pack(int'(floor), moving_up, moving_down, door_open, 1'b0, pending),
            pack(3, 0, 0, 0, 0, 8'h00));

        // Door extend at floor 3.
        req = 8'h08;
        step();
        req = 8'h00;
        step();
        found = 1'b0;
        for (int g = 0; g < 40; g++) begin
            if (door_open && !tmr_rst && tmr_period == 4'd10) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("ext found", int'(found), 1);
        req = 8'h08;
        step();
        req = 8'h00;
        chk("ext trst", int'(tmr_rst), 1);
        chk("ext door", int'(door_open), 1);
        chk("ext pend", int'(pending[3]), 0);
        cnt = 1;
        for (int g = 0; g < 40 && door_open; g++) begin
            step();
            if (door_open) cnt++;
        end
        chk("ext dwell", cnt, DT + 1);

        // SCAN ordering: 5 pending, calls for 1 and 4 while passing floor 2.
        do_reset();
        req = 8'h20;
        step();
        req = 8'h00;
        found = 1'b0;
        for (int g = 0; g < 200; g++) begin
            if (floor == 3'd2 && moving_up) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("scan reach2", int'(found), 1);
        req = 8'h12;
        step();
        req = 8'h00;
        n = 0;
        got = '{-1, -1, -1};
        prev = door_open;
        for (int g = 0; g < 400 && n < 3; g++) begin
            step();
            if (door_open && !prev) begin
                got[n] = int'(floor);
                n++;
            end
            prev = door_open;
        end
        chk("scan stops", n, 3);
        chk("scan stop0", got[0], 4);
        chk("scan stop1", got[1], 5);
        chk("scan stop2", got[2], 1);

        // Reset in the middle of an upward move.
        do_reset();
        req = 8'h80;
        step();
        req = 8'h00;
        found = 1'b0;
        for (int g = 0; g < 200; g++) begin
            if (floor == 3'd4 && moving_up) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("mid reach4", int'(found), 1);
        req = 8'h10;
        step();
        req = 8'h00;
        chk("mid before", dut_vec(), pack(4, 1, 0, 0, 0, 8'h90));
        rst = 1'b1;
        step();
        chk("mid reset", dut_vec(), pack(0, 0, 0, 0, 1, 8'h00));
        rst = 1'b0;
        step();
        chk("mid idle", dut_vec(), pack(0, 0, 0, 0, 0, 8'h00));

        // Randomized run against the reference model.
        for (int i = 0; i < 4000; i++) begin
            rv = (i == 0) || ($urandom_range(0, 999) == 0);
            rq = 8'h00;
            if ($urandom_range(0, 5) == 0) rq = 8'h01 << $urandom_range(0, 7);
            if ($urandom_range(0, 60) == 0) rq = 8'($urandom);
            rst = rv;
            req = rq;
            step();
            model_step(rv, rq);
            chk($sformatf("rand%0d", i), dut_vec(),
                pack(m_floor, m_mode == 1, m_mode == 2, m_mode == 3, m_trst, m_pend));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl.md
Name: elevator_ctrl

Overview:
- Car-motion controller for the elevator; sits directly upstream of `timer`.
- Drives the timer's `direction` and `rst` inputs and consumes its 4-bit `period` count to pace floor-to-floor travel and door dwell.
- Latches hall/car call pulses and serves them in SCAN order. Exports current floor, motion and door status to display/top level.

Parameters:
- NUM_FLOORS, 8, number of floors, legal range 2..16; floors indexed 0..NUM_FLOORS-1.
- FW, 3, floor index width, equal to clog2(NUM_FLOORS).
- TRAVEL_TICKS, 8, timer counts per floor transition, legal range 1..15.
- DOOR_TICKS, 12, timer counts door stays open, legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_FLOORS  call pulses, one bit per floor, sampled every cycle
- tmr_period  in  4  count from timer.period
- tmr_rst  out  1  to timer.rst; one-cycle pulse restarts the count at 0
- tmr_dir  out  1  to timer.direction; always 1 (count up) in this block
- floor  out  FW  current car floor
- moving_up  out  1  car travelling up
- moving_down  out  1  car travelling down
- door_open  out  1  door open
- pending  out  NUM_FLOORS  latched, unserved calls

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, floor=0, pending=0, moving_up=0, moving_down=0, door_open=0, tmr_rst=1, tmr_dir=1, last_dir=UP.
- Request latch: each cycle, pending |= req, and the bit being served is cleared in the same cycle (clear wins over set for that bit only).
- Phase start: every entry into MOVE_UP, MOVE_DOWN or DOOR_OPEN drives tmr_rst=1 for exactly one cycle (the entry cycle). The timer then reads 0 on the next cycle.
- Phase end: a phase ends when tmr_rst=0 and tmr_period==LIMIT-1. LIMIT is TRAVEL_TICKS for moves and DOOR_TICKS for the door.
  - Net effect: floor changes TRAVEL_TICKS+1 cycles after MOVE entry.
  - Door is open for DOOR_TICKS+1 cycles.
- States:
  - IDLE
    - pending[floor] → DOOR_OPEN; clear that bit.
    - else any pending above floor → MOVE_UP.
    - else any pending below → MOVE_DOWN.
    - else stay.
  - MOVE_UP / MOVE_DOWN
    - moving_up or moving_down =1; last_dir updated.
    - At phase end, floor ±1. Then evaluate the new floor:
      - pending[new floor] → DOOR_OPEN, clear the bit.
      - else re-enter the same MOVE state with a new tmr_rst pulse.
  - DOOR_OPEN
    - door_open=1.
    - At phase end, pick the next state:
      - requests exist in last_dir → MOVE in last_dir.
      - else requests exist in the opposite direction → MOVE opposite.
      - else IDLE.
- Boundaries and priorities:
  - Never MOVE_UP at floor NUM_FLOORS-1 and never MOVE_DOWN at floor 0; the direction selection logic guarantees this.
  - In IDLE, requests both above and below: UP wins.
  - req for the current floor during DOOR_OPEN: bit is not latched; tmr_rst is re-pulsed, so the dwell restarts.
  - req for the current floor during MOVE: the bit is latched and served on a later pass.
  - Simultaneous req on multiple floors: all are latched in the same cycle.
- rst mid-operation: return to reset values on the next edge; pending calls are lost and floor snaps to 0.
- The controller never depends on the timer counting down. tmr_dir is constant 1.

Decomposition:
- Shared package/header `elevator_defs` holds:
  - state encodings IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR_OPEN=3;
  - direction constants UP=1, DOWN=0;
  - default NUM_FLOORS, TRAVEL_TICKS and DOOR_TICKS.
- Sub-module `req_scan` (combinational): takes pending and floor; outputs any_above, any_below and at_floor.
- The top level contains the FSM, request register and output registers. The timer itself is instantiated alongside this block at the top level, not inside it.

Test Plan:
- Reset: hold rst for 2 cycles with req=8'hFF → floor=0, pending=0, door_open=0, moving_up=0, moving_down=0, tmr_rst=1; one cycle after release with req=0, state IDLE and tmr_rst=0.
- Single trip (bench timer model attached, defaults): at floor 0 idle, pulse req[3] →
  - moving_up=1;
  - floor steps to 1, 2, 3 at 9-cycle intervals;
  - at floor 3 door_open=1 for 13 cycles and pending[3] clears on door entry;
  - then IDLE with moving_up=0.
- Call at current floor: idle at floor 0, pulse req[0] → door_open=1 two cycles later, floor stays 0, no motion.
- SCAN order: at floor 2 moving up with pending[5]; pulse req[1] and req[4] → stops at 4, then 5, then reverses to 1. Door-open floors are recorded as 4, 5, 1.
- Door extend: during DOOR_OPEN at floor 3, pulse req[3] at timer period 10 → tmr_rst pulses, the door stays open 13 more cycles, and pending[3] stays 0.
- Reset mid-move: assert rst while MOVE_UP at floor 4 with pending=8'h90 → next cycle floor=0, pending=0, moving_up=0, state IDLE.
